tdm_demux: RTL
==============

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter WIDTH, default 1: bit width of each data slot.
REQ-002 Parameter ERR_W, default 8: width of the sync-error counter.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port din, input, WIDTH: serial TDM data, one slot per valid beat.
REQ-006 Port din_valid, input, 1: din and sync qualify this cycle.
REQ-007 Port sync, input, 1: marks the slot-0 beat of a frame; ignored when din_valid=0.
REQ-008 Ports out0, out1, out2, out3, output, WIDTH each: last complete frame, slots 0..3.
REQ-009 Port frame_valid, output, 1: one-cycle pulse when out0..out3 are updated.
REQ-010 Port locked, output, 1: high while in state LOCKED.
REQ-011 Port sync_err, output, 1: one-cycle pulse on any framing violation.
REQ-012 Port err_cnt, output, ERR_W: saturating count of sync_err pulses.

Function
REQ-013 The block SHALL run an FSM with states HUNT and LOCKED, plus a 2-bit slot counter and holding registers hold0..hold2.
REQ-014 A cycle with din_valid=0 SHALL change no state, counter, or register; gaps of any length are legal.
REQ-015 In HUNT, a beat with sync=0 SHALL be discarded without raising sync_err.
REQ-016 In HUNT, a beat with sync=1 SHALL store din in hold0, set slot=1, and enter LOCKED.
REQ-017 In LOCKED, a beat at slot 1 or 2 with sync=0 SHALL store din in hold[slot] and increment slot.
REQ-018 In LOCKED, a beat at slot 3 with sync=0 SHALL load out0..out2 from hold0..hold2 and out3 from din, pulse frame_valid, and set slot=0.
REQ-019 Outputs SHALL be registered: out0..out3 and frame_valid are visible the cycle after the slot-3 beat, which is a latency of 1.
REQ-020 Between frame_valid pulses, out0..out3 SHALL hold their values.
REQ-021 In LOCKED, a beat at slot 0 with sync=1 SHALL store din in hold0 and set slot=1.
REQ-022 In LOCKED, a beat at slot 0 with sync=0 (missing sync) SHALL pulse sync_err, discard the beat, and return to HUNT.
REQ-023 In LOCKED, a beat at slot 1..3 with sync=1 (early sync) SHALL pulse sync_err, drop the partial frame without pulsing frame_valid, store din in hold0, set slot=1, and stay LOCKED.
REQ-024 sync_err and frame_valid SHALL never assert in the same cycle.
REQ-025 err_cnt SHALL increment by 1 on each sync_err pulse.
REQ-026 err_cnt SHALL saturate at all-ones and never wrap.
REQ-027 locked SHALL be a registered decode of the FSM state.

Reset
REQ-028 While rst_n=0, the block SHALL immediately force state=HUNT, slot=0, hold0..hold2=0, out0..out3=0, frame_valid=0, sync_err=0, locked=0, and err_cnt=0.
REQ-029 Asserting reset mid-frame SHALL discard the partial frame; the first frame_valid after release requires a fresh sync.
REQ-030 Reset deassertion SHALL be synchronised to clk by the integrating level.

Structure
REQ-031 A shared package tdm_pkg SHALL hold the state typedef (HUNT, LOCKED), NUM_SLOTS=4, and SLOT_W=2.
REQ-032 One sub-module, tdm_slot_fsm, SHALL contain the FSM, slot counter, and error detection; data registers stay in tdm_demux.
REQ-033 No combinational path SHALL run from inputs to outputs.

Verification (WIDTH=4)
REQ-034 Bench SHALL cover: reset, then back-to-back beats sync=1 with A,B,C,D -> locked=1 after the first beat; out0..3=A,B,C,D and frame_valid=1 one cycle after beat D.
REQ-035 Bench SHALL cover: same frame with din_valid=0 gaps of 0..3 cycles between beats -> identical outputs, exactly one frame_valid pulse.
REQ-036 Bench SHALL cover: frame 1,2 then sync=1 with 5,6,7,8 -> sync_err pulse on the "5" beat, err_cnt=1, no frame_valid for 1,2, then out=5,6,7,8.
REQ-037 Bench SHALL cover: a full frame, then a slot-0 beat with sync=0 -> sync_err, locked=0; following non-sync beats ignored; the next sync relocks.
REQ-038 Bench SHALL cover: rst_n low after 2 beats of a frame -> all outputs 0 at once, with no clock edge needed; after release 2 non-sync beats give no output.
REQ-039 Bench SHALL cover: ERR_W=2 with 5 early-sync errors -> err_cnt sequence 1,2,3,3,3.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM demultiplexer.
package tdm_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_t;

   localparam int NUM_SLOTS = 4;
   localparam int SLOT_W    = 2;

   localparam logic [SLOT_W-1:0] FIRST_SLOT = '0;
   localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(NUM_SLOTS - 1);

endpackage

// File: rtl/tdm_slot_fsm.sv
// Frame-alignment FSM: tracks the slot position, flags framing violations and
// issues the write strobes used by the data registers in tdm_demux.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   HUNT   | no frame alignment; non-sync beats are dropped silently
//   LOCKED | aligned; slot counts the position of the next beat in frame
module tdm_slot_fsm
   import tdm_pkg::*;
#(
   parameter int ERR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              din_valid,
   input  logic              sync,
   output logic              hold_we,
   output logic [SLOT_W-1:0] hold_sel,
   output logic              out_we,
   output logic              locked,
   output logic              sync_err,
   output logic [ERR_W-1:0]  err_cnt
);

   tdm_state_t        state_q, state_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic              err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= HUNT;
         slot_q   <= FIRST_SLOT;
         locked   <= 1'b0;
         sync_err <= 1'b0;
         err_cnt  <= '0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         locked   <= (state_d == LOCKED);
         sync_err <= err_d;
         if (err_d && (err_cnt != '1))
            err_cnt <= err_cnt + 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      err_d    = 1'b0;
      hold_we  = 1'b0;
      hold_sel = slot_q;
      out_we   = 1'b0;
      if (din_valid) begin
         unique case (state_q)
            HUNT: begin
               if (sync) begin
                  hold_we  = 1'b1;
                  hold_sel = FIRST_SLOT;
                  slot_d   = FIRST_SLOT + 1'b1;
                  state_d  = LOCKED;
               end
            end
            LOCKED: begin
               if (slot_q == FIRST_SLOT) begin
                  if (sync) begin
                     hold_we  = 1'b1;
                     hold_sel = FIRST_SLOT;
                     slot_d   = FIRST_SLOT + 1'b1;
                  end else begin
                     err_d   = 1'b1;
                     slot_d  = FIRST_SLOT;
                     state_d = HUNT;
                  end
               end else if (sync) begin
                  // Early sync: abandon the partial frame and restart on this beat.
                  err_d    = 1'b1;
                  hold_we  = 1'b1;
                  hold_sel = FIRST_SLOT;
                  slot_d   = FIRST_SLOT + 1'b1;
               end else if (slot_q == LAST_SLOT) begin
                  out_we = 1'b1;
                  slot_d = FIRST_SLOT;
               end else begin
                  hold_we = 1'b1;
                  slot_d  = slot_q + 1'b1;
               end
            end
            default: begin
               state_d = HUNT;
               slot_d  = FIRST_SLOT;
            end
         endcase
      end
   end

endmodule

// File: rtl/tdm_demux.sv
// 4-slot TDM demultiplexer: collects slots 0..2 in holding registers and
// publishes the whole frame on the slot-3 beat.
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic             frame_valid,
   output logic             locked,
   output logic             sync_err,
   output logic [ERR_W-1:0] err_cnt
);

   logic              hold_we;
   logic [SLOT_W-1:0] hold_sel;
   logic              out_we;
   logic [WIDTH-1:0]  hold0, hold1, hold2;

   tdm_slot_fsm #(
      .ERR_W (ERR_W)
   ) u_slot_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .din_valid (din_valid),
      .sync      (sync),
      .hold_we   (hold_we),
      .hold_sel  (hold_sel),
      .out_we    (out_we),
      .locked    (locked),
      .sync_err  (sync_err),
      .err_cnt   (err_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold0 <= '0;
         hold1 <= '0;
         hold2 <= '0;
      end else if (hold_we) begin
         case (hold_sel)
            2'd0:    hold0 <= din;
            2'd1:    hold1 <= din;
            2'd2:    hold2 <= din;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out0        <= '0;
         out1        <= '0;
         out2        <= '0;
         out3        <= '0;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= out_we;
         if (out_we) begin
            out0 <= hold0;
            out1 <= hold1;
            out2 <= hold2;
            out3 <= din;
         end
      end
   end

endmodule
